// File: rtl/md_unit.sv
// Multiply/divide unit for pipeline stage E: sequences HI/LO through fixed-latency
// mult/div operations, handles mthi/mtlo/mfhi/mflo and requests stalls while busy.
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_en,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;

    md_op_e             op;
    logic               is_mul;
    logic               is_div;
    logic               start;

    logic signed [63:0] rs_sx;
    logic signed [63:0] rt_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] rs_s;
    logic signed [31:0] div_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] div_u;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;

    assign op = md_op_e'(E_md_op);

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV)  || (op == OP_DIVU);
        start  = E_en && (is_mul || is_div) && (state_q == ST_IDLE);
    end

    assign rs_sx  = {{32{E_rs[31]}}, E_rs};
    assign rt_sx  = {{32{E_rt[31]}}, E_rt};
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {32'd0, E_rs} * {32'd0, E_rt};

    // Divisor is forced to 1 in the special cases so the dividers never see /0 or overflow.
    assign div_zero = (E_rt == 32'd0);
    assign div_ovf  = (E_rs == 32'h8000_0000) && (E_rt == 32'hFFFF_FFFF);
    assign rs_s     = E_rs;
    assign div_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(E_rt);
    assign quot_s   = rs_s / div_s;
    assign rem_s    = rs_s % div_s;
    assign div_u    = div_zero ? 32'd1 : E_rt;
    assign quot_u   = E_rs / div_u;
    assign rem_u    = E_rs % div_u;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (div_zero) begin
                    res_hi = E_rs;
                    res_lo = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            OP_DIVU: begin
                if (div_zero) begin
                    res_hi = E_rs;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // Result is computed at the start edge and held in pend_* until the counter expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                    state_d   = ST_BUSY;
                end else if (E_en && (op == OP_MTHI)) begin
                    hi_d = E_rs;
                end else if (E_en && (op == OP_MTLO)) begin
                    lo_d = E_rs;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign md_stall = D_md && (busy || start);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Reads see only committed HI/LO; pending results are never bypassed.
    always_comb begin
        case (op)
            OP_MFHI: md_out = hi_q;
            OP_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table of mult/div operations with a
// result scoreboard, plus hand-written reset, mthi/mtlo and abort sequences.
module tb_md_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_en = 1'b0;
    logic [3:0]  E_md_op = 4'd0;
    logic [31:0] E_rs = 32'd0;
    logic [31:0] E_rt = 32'd0;
    logic        D_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } sb_t;

    vec_t        vecs[12];
    sb_t         sb_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_en     (E_en),
        .E_md_op  (E_md_op),
        .E_rs     (E_rs),
        .E_rt     (E_rt),
        .D_md     (D_md),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic d_md);
        @(negedge clk);
        E_en    = en;
        E_md_op = op;
        E_rs    = rs;
        E_rt    = rt;
        D_md    = d_md;
    endtask

    task automatic checkOutput();
        sb_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
            model_hi = e.hi;
            model_lo = e.lo;
            E_en = 1'b1; E_md_op = 4'd6; D_md = 1'b1;
            #1 check("mflo_out", md_out, e.lo);
            check("stall_after_done", {31'd0, md_stall}, 32'd0);
            E_md_op = 4'd5;
            #1 check("mfhi_out", md_out, e.hi);
            E_en = 1'b0; E_md_op = 4'd0; D_md = 1'b0;
        end
    endtask

    task automatic runOp(input vec_t v, input int idx);
        int   lat;
        int   cycles;
        logic d_start;
        sb_t  e;
        lat     = (v.op == 4'd1 || v.op == 4'd2) ? MULT_LAT : DIV_LAT;
        cycles  = 0;
        d_start = (idx % 2 == 0);
        applyStimulus(1'b1, v.op, v.rs, v.rt, d_start);
        #1 check("start_stall", {31'd0, md_stall}, {31'd0, d_start});
        e.hi = v.exp_hi;
        e.lo = v.exp_lo;
        sb_q.push_back(e);
        @(negedge clk);
        while (busy && cycles < 100) begin
            cycles++;
            D_md = (idx == 0) ? 1'b1 : cycles[0];
            E_rs = $urandom;
            E_rt = $urandom;
            if (cycles == 2) begin
                E_en = 1'b1; E_md_op = 4'd8;
            end else if (cycles == 3) begin
                E_en = 1'b1; E_md_op = 4'd1;
            end else begin
                E_en = 1'b0; E_md_op = 4'd0;
            end
            #1 check("busy_stall", {31'd0, md_stall}, {31'd0, D_md});
            if (cycles == 1) begin
                check("hold_hi", hi, model_hi);
                check("hold_lo", lo, model_lo);
            end
            @(negedge clk);
        end
        E_en = 1'b0; E_md_op = 4'd0; D_md = 1'b0;
        check("busy_cycles", 32'(cycles), 32'(lat));
        checkOutput();
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{4'd2, 32'hFFFF_FFFF,  32'd2,         32'd1,         32'hFFFF_FFFE};
        vecs[2]  = '{4'd3, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{4'd4, 32'd100,        32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4]  = '{4'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5]  = '{4'd3, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[6]  = '{4'd4, 32'd100,        32'd7,         32'd2,         32'd14};
        vecs[7]  = '{4'd3, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{4'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[9]  = '{4'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        vecs[10] = '{4'd1, 32'h8000_0000,  32'd7,         32'hFFFF_FFFC, 32'h8000_0000};
        vecs[11] = '{4'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        E_en = 1'b1; E_md_op = 4'd5; D_md = 1'b1;
        #1 check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, md_stall}, 32'd0);
        check("reset_md_out", md_out, 32'd0);
        E_en = 1'b0; E_md_op = 4'd0; D_md = 1'b0;
        reset = 1'b1;

        // mthi / mtlo, and a bubble carrying mtlo must not write
        applyStimulus(1'b1, 4'd7, 32'h1234_5678, 32'd0, 1'b0);
        applyStimulus(1'b1, 4'd8, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check("mthi", hi, 32'h1234_5678);
        applyStimulus(1'b0, 4'd8, 32'h5555_5555, 32'd0, 1'b0);
        check("mtlo", lo, 32'h9ABC_DEF0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check("mtlo_bubble", lo, 32'h9ABC_DEF0);
        model_hi = 32'h1234_5678;
        model_lo = 32'h9ABC_DEF0;

        for (int i = 0; i < 12; i++) runOp(vecs[i], i);

        // Reset in the middle of a divide discards the pending result
        applyStimulus(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
